// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants and request bundle for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;
  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int DEPTH_DEF    = 5000;
  localparam int LOCK_MAX_DEF = 16;
  localparam int NUM_M        = 2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master port bundle; the lock signal exists only with MEM_ARB_LOCK_EN.
interface onchip_mem_arbiter_if;
  import onchip_mem_arb_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
`ifdef MEM_ARB_LOCK_EN
  logic              lock;
`endif
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
`ifdef MEM_ARB_LOCK_EN
    output lock,
`endif
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
`ifdef MEM_ARB_LOCK_EN
    input  lock,
`endif
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with registered last_grant; optional lock hold
// (MEM_ARB_LOCK_EN) bounded by LOCK_MAX consecutive locked cycles.
module rr_arb2
  import onchip_mem_arb_pkg::*;
#(
`ifdef MEM_ARB_LOCK_EN
  parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
`ifdef MEM_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] grant
);
  logic       last_grant;
  logic [1:0] rr_grant;

  // On a tie the master that did not win last time gets the slot.
  always_comb begin
    rr_grant = req;
    if (req == 2'b11) rr_grant = last_grant ? 2'b01 : 2'b10;
  end

`ifdef MEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt;
  logic          hold;

  // Holding reserves the slot for the owner even when it is idle.
  assign hold = lock[last_grant] && (lock_cnt != CW'(LOCK_MAX));

  always_comb begin
    grant = rr_grant;
    if (hold) grant = req & (last_grant ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         lock_cnt <= '0;
    else if (hold)                      lock_cnt <= lock_cnt + 1'b1;
    else if (lock_cnt == CW'(LOCK_MAX)) lock_cnt <= '0;
    else if (|grant && lock[grant[1]])  lock_cnt <= CW'(1);
    else                                lock_cnt <= '0;
  end
`else
  assign grant = rr_grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= M1;
    else if (|grant) last_grant <= grant[1];
  end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port 1-cycle-latency RAM between two Avalon-MM masters.
// Optional grant locking is compiled in with MEM_ARB_LOCK_EN.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
`ifdef MEM_ARB_LOCK_EN
  , parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  req_t                           rq [NUM_M];
  logic [NUM_M-1:0]               req, grant, rdv;
  logic [NUM_M-1:0][DATA_W-1:0]   rdd;
  req_t                           g;
  logic                           sel, in_rng, rd_acc;
  logic                           rd_pend, rd_owner, rd_oor;

  assign rq[0] = {m0.address, m0.byteenable, m0.read, m0.write, m0.writedata};
  assign rq[1] = {m1.address, m1.byteenable, m1.read, m1.write, m1.writedata};

  for (genvar i = 0; i < NUM_M; i++) begin : g_req
    assign req[i] = rq[i].rd | rq[i].wr;
  end

  rr_arb2 #(
`ifdef MEM_ARB_LOCK_EN
    .LOCK_MAX(LOCK_MAX)
`endif
  ) u_arb (
    .clk  (clk),
    .rst_n(reset_n),
    .req  (req),
`ifdef MEM_ARB_LOCK_EN
    .lock ({m1.lock, m0.lock}),
`endif
    .grant(grant)
  );

  assign sel    = grant[1];
  assign g      = rq[sel];
  assign in_rng = 32'(g.addr) < 32'(DEPTH);
  // A write with read also high is a write; the read half is dropped.
  assign rd_acc = (|grant) & ~g.wr;

  assign mem_address    = g.addr;
  assign mem_byteenable = g.be;
  assign mem_writedata  = g.wdata;
  assign mem_chipselect = |grant;
  assign mem_write      = (|grant) & g.wr & in_rng;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= M0;
      rd_oor   <= 1'b0;
    end else begin
      rd_pend  <= rd_acc;
      if (rd_acc) begin
        rd_owner <= sel;
        rd_oor   <= ~in_rng;
      end
    end
  end

  // Return path: data passes through on the valid cycle, then is held.
  for (genvar i = 0; i < NUM_M; i++) begin : g_ret
    logic              vld;
    logic [DATA_W-1:0] rdat, hold_q;
    assign vld  = rd_pend && (rd_owner == 1'(i));
    assign rdat = rd_oor ? '0 : mem_readdata;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  hold_q <= '0;
      else if (vld)  hold_q <= rdat;
    end
    assign rdv[i] = vld;
    assign rdd[i] = vld ? rdat : hold_q;
  end

  assign m0.waitrequest   = req[0] & ~grant[0];
  assign m1.waitrequest   = req[1] & ~grant[1];
  assign m0.readdatavalid = rdv[0];
  assign m1.readdatavalid = rdv[1];
  assign m0.readdata      = rdd[0];
  assign m1.readdata      = rdd[1];
endmodule
